// File: rtl/siso_shift_pkg.sv
// Shared FSM state type and counter-width helper for the serial shift controller.
package siso_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A counter for values 0..n-1 still needs one bit when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/siso_bit_timer.sv
// Bit-period divider and bit counter: strobe on the last divider cycle of each bit, last on the final bit.
// Combinational strobe/last from registered counters; no backpressure, counts only while run is high.
module siso_bit_timer
    import siso_shift_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DIV      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic strobe,
    output logic last
);

    localparam int DW = cnt_width(DIV);
    localparam int BW = cnt_width(BITWIDTH);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(BITWIDTH - 1);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;

    assign strobe = run && (div_q == DIV_MAX);
    assign last   = strobe && (bit_q == BIT_MAX);

    always_comb begin
        div_d = div_q;
        bit_d = bit_q;
        if (clear) begin
            div_d = '0;
            bit_d = '0;
        end else if (run) begin
            if (strobe) begin
                div_d = '0;
                // Return to zero after the final bit rather than wrapping past BITWIDTH-1.
                bit_d = last ? '0 : bit_q + BW'(1);
            end else begin
                div_d = div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/siso_shift_ctrl.sv
// Parallel-in word shifted out MSB first on ser_out while ser_in is captured into send_msg.
// Word accepted in IDLE only; result held in DONE with send_val until send_rdy.
module siso_shift_ctrl
    import siso_shift_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DIV      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] recv_msg,
    input  logic                recv_val,
    output logic                recv_rdy,
    output logic [BITWIDTH-1:0] send_msg,
    output logic                send_val,
    input  logic                send_rdy,
    input  logic                ser_in,
    output logic                ser_out,
    output logic                ser_strobe,
    output logic                frame
);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] shift_q, shift_d;
    logic [BITWIDTH-1:0] send_msg_q, send_msg_d;
    logic                load, running, strobe, last;

    assign load    = (state_q == IDLE) && recv_val;
    assign running = (state_q == SHIFT);

    siso_bit_timer #(
        .BITWIDTH (BITWIDTH),
        .DIV      (DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .run    (running),
        .strobe (strobe),
        .last   (last)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        send_msg_d = send_msg_q;
        case (state_q)
            IDLE: begin
                if (recv_val) begin
                    shift_d = recv_msg;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (strobe) begin
                    shift_d = {shift_q[BITWIDTH-2:0], ser_in};
                    if (last) begin
                        state_d    = DONE;
                        send_msg_d = {shift_q[BITWIDTH-2:0], ser_in};
                    end
                end
            end
            DONE: begin
                // Handshake only returns to IDLE; the next word is taken a cycle later.
                if (send_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            send_msg_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            send_msg_q <= send_msg_d;
        end
    end

    assign recv_rdy   = (state_q == IDLE);
    assign send_val   = (state_q == DONE);
    assign frame      = running;
    assign ser_out    = running & shift_q[BITWIDTH-1];
    assign ser_strobe = strobe;
    assign send_msg   = send_msg_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
module tb_siso_shift_ctrl;

    localparam int BW = 8;
    localparam int DV = 2;
    localparam int NB = BW * DV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [BW-1:0] recv_msg, send_msg;
    logic          recv_val, recv_rdy, send_val, send_rdy;
    logic          ser_in, ser_out, ser_strobe, frame;
    logic          loop, si;

    assign ser_in = loop ? ser_out : si;

    siso_shift_ctrl #(.BITWIDTH(BW), .DIV(DV)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .recv_msg   (recv_msg),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .send_msg   (send_msg),
        .send_val   (send_val),
        .send_rdy   (send_rdy),
        .ser_in     (ser_in),
        .ser_out    (ser_out),
        .ser_strobe (ser_strobe),
        .frame      (frame)
    );

    // Second instance with one clock per bit.
    logic [BW-1:0] d1_recv_msg, d1_send_msg;
    logic          d1_recv_val, d1_recv_rdy, d1_send_val, d1_send_rdy;
    logic          d1_si, d1_ser_out, d1_ser_strobe, d1_frame;

    siso_shift_ctrl #(.BITWIDTH(BW), .DIV(1)) u_dut_div1 (
        .clk        (clk),
        .reset      (reset),
        .recv_msg   (d1_recv_msg),
        .recv_val   (d1_recv_val),
        .recv_rdy   (d1_recv_rdy),
        .send_msg   (d1_send_msg),
        .send_val   (d1_send_val),
        .send_rdy   (d1_send_rdy),
        .ser_in     (d1_si),
        .ser_out    (d1_ser_out),
        .ser_strobe (d1_ser_strobe),
        .frame      (d1_frame)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 shifting (k = cycles since acceptance), 2 result waiting.
    int            mode = 0;
    int            k = 0;
    logic [BW-1:0] word = '0, cap = '0, last_msg = '0;
    logic          e_rdy, e_val, e_frame, e_out, e_stb;

    function automatic void predict();
        e_rdy   = (mode == 0);
        e_val   = (mode == 2);
        e_frame = (mode == 1);
        e_out   = (mode == 1) ? word[BW - 1 - (k - 1) / DV] : 1'b0;
        e_stb   = (mode == 1) && (k % DV == 0);
    endfunction

    task automatic check_all(input string tag);
        predict();
        chk({tag, ".ctl"}, {27'd0, recv_rdy, send_val, frame, ser_out, ser_strobe},
            {27'd0, e_rdy, e_val, e_frame, e_out, e_stb});
        chk({tag, ".msg"}, {24'd0, send_msg}, {24'd0, last_msg});
    endtask

    task automatic tick();
        @(posedge clk);
        case (mode)
            0: if (recv_val) begin
                mode = 1; k = 1; word = recv_msg; cap = '0;
            end
            1: begin
                if (e_stb) cap = {cap[BW-2:0], (loop ? e_out : si)};
                if (k == NB) begin
                    mode = 2;
                    last_msg = cap;
                end else begin
                    k++;
                end
            end
            default: if (send_rdy) mode = 0;
        endcase
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        mode = 0; k = 0; cap = '0; last_msg = '0;
        check_all("rst");
        @(negedge clk);
        reset = 1'b1;
        check_all("rst_rel");
    endtask

    logic [BW-1:0] pat;

    initial begin
        reset = 1'b0; recv_msg = '0; recv_val = 1'b0; send_rdy = 1'b0; loop = 1'b0; si = 1'b0;
        d1_recv_msg = '0; d1_recv_val = 1'b0; d1_send_rdy = 1'b0; d1_si = 1'b1;
        @(negedge clk);
        apply_reset();
        chk("d1_rst_rdy", {31'd0, d1_recv_rdy}, 32'd1);

        // DIV=1 capture: eight back-to-back strobes, all-ones word captured.
        d1_recv_val = 1'b1;
        @(negedge clk);
        d1_recv_val = 1'b0;
        for (int i = 0; i < BW; i++) begin
            chk("d1_stb", {31'd0, d1_ser_strobe}, 32'd1);
            @(negedge clk);
        end
        chk("d1_val", {31'd0, d1_send_val}, 32'd1);
        chk("d1_msg", {24'd0, d1_send_msg}, 32'hFF);
        d1_send_rdy = 1'b1;
        @(negedge clk);
        chk("d1_idle", {31'd0, d1_recv_rdy}, 32'd1);

        // Loopback of 0xA5, each bit held DV cycles, result at T+17.
        loop = 1'b1; recv_msg = 8'hA5; recv_val = 1'b1; send_rdy = 1'b0;
        tick();
        recv_val = 1'b0;
        pat = 8'hA5;
        for (int i = 0; i < NB; i++) begin
            chk("lb_out", {31'd0, ser_out}, {31'd0, pat[BW - 1 - i / DV]});
            tick();
        end
        chk("lb_val", {31'd0, send_val}, 32'd1);
        chk("lb_msg", {24'd0, send_msg}, 32'hA5);

        // Backpressure in DONE, with recv_val asserted on the handshake cycle.
        for (int i = 0; i < 5; i++) tick();
        recv_val = 1'b1; recv_msg = 8'h5A; send_rdy = 1'b1;
        tick();
        recv_val = 1'b0;
        tick();

        // Idle noise on ser_in.
        loop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            si = 1'($urandom);
            tick();
        end

        // Reset while bit 3 is on the line.
        recv_val = 1'b1; recv_msg = 8'($urandom); si = 1'b1;
        tick();
        recv_val = 1'b0;
        for (int i = 0; i < NB && !(mode == 1 && (k - 1) / DV == 3); i++) tick();
        apply_reset();
        for (int i = 0; i < NB + 4; i++) tick();

        // Back-to-back words with send_rdy held high.
        loop = 1'b1; send_rdy = 1'b1; recv_val = 1'b1; recv_msg = 8'h3C;
        tick();
        recv_msg = 8'hC3;
        for (int i = 0; i < NB + 1; i++) tick();
        chk("b2b_0", {24'd0, send_msg}, 32'h3C);
        for (int i = 0; i < NB + 2; i++) tick();
        chk("b2b_1", {24'd0, send_msg}, 32'hC3);
        recv_val = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            recv_val = ($urandom_range(0, 3) == 0);
            recv_msg = 8'($urandom);
            send_rdy = ($urandom_range(0, 2) == 0);
            si       = 1'($urandom);
            if (mode == 0) loop = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/siso_shift_ctrl.md
SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, giving the shift word width; legal values are 2 or more.
REQ-002 The block SHALL have parameter DIV, default 4, giving clock cycles per serial bit; legal values are 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port recv_msg, input, BITWIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port recv_val, input, 1 bit: recv_msg valid.
REQ-007 The block SHALL have port recv_rdy, output, 1 bit: block can accept a word.
REQ-008 The block SHALL have port send_msg, output, BITWIDTH bits: word captured from ser_in.
REQ-009 The block SHALL have port send_val, output, 1 bit: send_msg valid.
REQ-010 The block SHALL have port send_rdy, input, 1 bit: consumer accepts send_msg.
REQ-011 The block SHALL have port ser_in, input, 1 bit: serial data in.
REQ-012 The block SHALL have port ser_out, output, 1 bit: serial data out, MSB first.
REQ-013 The block SHALL have port ser_strobe, output, 1 bit: one-cycle pulse on each bit shift.
REQ-014 The block SHALL have port frame, output, 1 bit: high while a word is being shifted.

Function
REQ-015 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 In IDLE the block SHALL drive recv_rdy=1; recv_rdy SHALL be 0 in SHIFT and DONE.
REQ-017 When recv_val and recv_rdy are both 1, the block SHALL load recv_msg into the shift register, clear the bit counter and divider counter, and enter SHIFT.
REQ-018 In IDLE and SHIFT the block SHALL ignore recv_val when no transfer occurs; no state SHALL change.
REQ-019 In SHIFT the divider SHALL count 0 to DIV-1 and wrap to 0.
REQ-020 When the divider equals DIV-1, the block SHALL assert ser_strobe, shift the register left with ser_in entering bit 0, and increment the bit counter.
REQ-021 The block SHALL drive ser_out = shift register MSB while in SHIFT, and 0 in IDLE and DONE.
REQ-022 The block SHALL drive frame=1 only in SHIFT.
REQ-023 The strobe at bit counter value BITWIDTH-1 SHALL move the FSM to DONE.
REQ-024 Timing: with the transfer in cycle T, SHIFT SHALL begin in cycle T+1, the final strobe SHALL occur at T+BITWIDTH*DIV, and send_val SHALL rise at T+BITWIDTH*DIV+1.
REQ-025 In DONE the block SHALL drive send_val=1 and hold send_msg equal to the shift register, stable until the handshake.
REQ-026 When send_val and send_rdy are both 1, the block SHALL return to IDLE; a new word SHALL NOT be accepted in that same cycle.
REQ-027 send_msg SHALL retain its last value outside DONE but is only meaningful while send_val=1.
REQ-028 Bit and divider counters SHALL be sized to hold BITWIDTH-1 and DIV-1 respectively, with no overflow wrap beyond those values.

Reset
REQ-029 Asserting reset low SHALL immediately force state=IDLE, shift register=0, counters=0, and send_msg=0.
REQ-030 After reset the outputs SHALL be recv_rdy=1, send_val=0, ser_out=0, ser_strobe=0, frame=0.
REQ-031 A reset during SHIFT or DONE SHALL discard the in-flight word with no send_val pulse.
REQ-032 Operation SHALL resume on the first clock edge after reset deasserts.

Structure
REQ-033 The FSM state enum typedef SHALL reside in shared package siso_shift_pkg.
REQ-034 The block SHALL instantiate one sub-module, siso_bit_timer, containing the divider and bit counter that produce the strobe and last-bit flags.
REQ-035 The shift register and FSM SHALL reside in siso_shift_ctrl, using the same asynchronous active-low reset.

Verification
REQ-036 Loopback test: with BITWIDTH=8, DIV=2, ser_in tied to ser_out, send 0xA5. Required: ser_out=1,0,1,0,0,1,0,1, each bit held 2 cycles; send_val at T+17 with send_msg=0xA5.
REQ-037 Capture test: with BITWIDTH=8, DIV=1, ser_in=1, send 0x00. Required: 8 consecutive ser_strobe pulses; send_msg=0xFF at T+9.
REQ-038 Backpressure test: hold send_rdy=0 for 5 cycles in DONE. Required: send_val=1 with send_msg stable, and recv_rdy=0 throughout; IDLE is entered one cycle after send_rdy=1.
REQ-039 Reset test: drive reset low at bit 3 of a transfer. Required: frame=0 and recv_rdy=1 immediately; send_val is never asserted.
REQ-040 Back-to-back test: hold recv_val=1 with 0x3C then 0xC3, with send_rdy=1. Required: second transfer occurs one cycle after the send handshake, and both words are received correctly.
REQ-041 Idle noise test: toggle ser_in while in IDLE. Required: ser_strobe=0, ser_out=0, and no state change.
